// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle control sequencer for the single-bus ALU datapath
// Every strobe is registered and is set at the edge that enters the state which owns it.
module alu_op_sequencer #(
  parameter int NREG       = 16,
  parameter int MULDIV_LAT = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_opcode,
  input  logic [3:0]      req_ra,
  input  logic [3:0]      req_rb,
  input  logic [3:0]      req_rd,
  output logic [NREG-1:0] r_out_sel,
  output logic [NREG-1:0] r_in_sel,
  output logic            y_in,
  output logic [4:0]      alu_opcode,
  output logic            zlo_out,
  output logic            zhi_out,
  output logic            lo_in,
  output logic            hi_in,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_EXEC, S_WB_LO, S_WB_HI, S_ERR} state_t;

  localparam logic [3:0] LAT = 4'(MULDIV_LAT);

  state_t     state;
  logic [4:0] op_q;
  logic [3:0] rb_q;
  logic [3:0] rd_q;
  logic [3:0] cnt;

  function automatic logic [NREG-1:0] sel(input logic [3:0] idx);
    return NREG'(1) << idx;
  endfunction

  function automatic logic is_md(input logic [4:0] op);
    return (op == 5'd3) || (op == 5'd4);
  endfunction

  function automatic logic is_b_only(input logic [4:0] op);
    return (op == 5'd12) || (op == 5'd15);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return (op != 5'd0) && (op <= 5'd15);
  endfunction

  assign req_ready = (state == S_IDLE) && !clr;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      op_q       <= '0;
      rb_q       <= '0;
      rd_q       <= '0;
      cnt        <= '0;
      r_out_sel  <= '0;
      r_in_sel   <= '0;
      y_in       <= 1'b0;
      alu_opcode <= '0;
      zlo_out    <= 1'b0;
      zhi_out    <= 1'b0;
      lo_in      <= 1'b0;
      hi_in      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_out_sel <= '0;
      r_in_sel  <= '0;
      y_in      <= 1'b0;
      zlo_out   <= 1'b0;
      zhi_out   <= 1'b0;
      lo_in     <= 1'b0;
      hi_in     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q <= req_opcode;
            rb_q <= req_rb;
            rd_q <= req_rd;
            if (!is_legal(req_opcode)) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else if (is_b_only(req_opcode)) begin
              state      <= S_EXEC;
              r_out_sel  <= sel(req_rb);
              alu_opcode <= req_opcode;
              cnt        <= '0;
            end else begin
              state     <= S_LOAD_A;
              r_out_sel <= sel(req_ra);
              y_in      <= 1'b1;
            end
          end
        end
        S_LOAD_A: begin
          state      <= S_EXEC;
          r_out_sel  <= sel(rb_q);
          alu_opcode <= op_q;
          cnt        <= is_md(op_q) ? LAT : 4'd0;
        end
        S_EXEC: begin
          // mul/div hold B on the bus while the long combinational path settles
          if (cnt != 4'd0) begin
            cnt       <= cnt - 4'd1;
            r_out_sel <= sel(rb_q);
          end else begin
            state   <= S_WB_LO;
            zlo_out <= 1'b1;
            if (is_md(op_q)) begin
              lo_in <= 1'b1;
            end else begin
              r_in_sel <= sel(rd_q);
              done     <= 1'b1;
            end
          end
        end
        S_WB_LO: begin
          if (is_md(op_q)) begin
            state   <= S_WB_HI;
            zhi_out <= 1'b1;
            hi_in   <= 1'b1;
            done    <= 1'b1;
          end else begin
            state      <= S_IDLE;
            alu_opcode <= '0;
          end
        end
        S_WB_HI: begin
          state      <= S_IDLE;
          alu_opcode <= '0;
        end
        default: begin
          state      <= S_IDLE;
          alu_opcode <= '0;
        end
      endcase
    end
  end

  a_bus_excl: assert property (@(posedge clk) disable iff (clr)
    $onehot0({r_out_sel, zlo_out, zhi_out}));
  a_load_excl: assert property (@(posedge clk) disable iff (clr)
    $onehot0({r_in_sel, lo_in, hi_in}));

endmodule
